// File: rtl/irq_ctrl.sv
// 6502 bus interrupt controller: synchronizes up to eight sources, latches them
// as pending (level or edge per source), masks, prioritises and drives irq.
module irq_ctrl #(
  parameter int NSRC = 8
) (
  input  logic            clk,
  input  logic            rst,
  output logic [7:0]      dbr,
  input  logic [7:0]      dbw,
  input  logic [1:0]      addr,
  input  logic            we,
  input  logic [NSRC-1:0] src,
  output logic            irq
);

  logic [NSRC-1:0] s1, s2, s3;
  logic [NSRC-1:0] pend, mask, mode;
  logic [NSRC-1:0] act, clr, swt, pend_nxt;
  logic            wr_pend, wr_mask, wr_mode, wr_vec;
  logic            any;
  logic [2:0]      idx;
  logic [7:0]      rd;

  // Lowest set index wins; an empty vector encodes as 0.
  function automatic logic [2:0] lowest(input logic [NSRC-1:0] v);
    lowest = 3'd0;
    for (int i = NSRC - 1; i >= 0; i--) begin
      if (v[i]) lowest = 3'(i);
    end
  endfunction

  function automatic logic [7:0] ext(input logic [NSRC-1:0] v);
    ext = '0;
    ext[NSRC-1:0] = v;
  endfunction

  assign wr_pend = we && (addr == 2'd0);
  assign wr_mask = we && (addr == 2'd1);
  assign wr_mode = we && (addr == 2'd2);
  assign wr_vec  = we && (addr == 2'd3);

  assign act = pend & mask;
  assign any = |act;
  assign idx = lowest(act);
  assign clr = wr_pend ? dbw[NSRC-1:0] : '0;

  always_comb begin
    swt      = '0;
    pend_nxt = '0;
    for (int i = 0; i < NSRC; i++) begin
      // Only sources that exist can match, so out-of-range triggers fall away.
      swt[i] = wr_vec && (dbw[2:0] == 3'(i)) && mode[i];
      // Edge mode: set beats a simultaneous W1C clear.
      pend_nxt[i] = mode[i] ? ((s2[i] & ~s3[i]) | swt[i] | (pend[i] & ~clr[i]))
                            : s2[i];
    end
  end

  always_comb begin
    rd = 8'h00;
    case (addr)
      2'd0: rd = ext(pend);
      2'd1: rd = ext(mask);
      2'd2: rd = ext(mode);
      2'd3: rd = {any, 4'b0000, idx};
      default: rd = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1   <= '0;
      s2   <= '0;
      s3   <= '0;
      pend <= '0;
      mask <= '0;
      mode <= '0;
      dbr  <= 8'h00;
      irq  <= 1'b0;
    end else begin
      s1   <= src;
      s2   <= s1;
      s3   <= s2;
      pend <= pend_nxt;
      if (wr_mask) mask <= dbw[NSRC-1:0];
      if (wr_mode) mode <= dbw[NSRC-1:0];
      dbr  <= rd;
      irq  <= any;
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed bench for irq_ctrl: one full-width instance and one NSRC=4 instance
// for the out-of-range software trigger.
module tb_irq_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] dbr, dbr4;
  logic [7:0] dbw = 8'h00;
  logic [1:0] addr = 2'd0;
  logic       we = 1'b0, we4 = 1'b0;
  logic [7:0] src = 8'h00;
  logic [3:0] src4 = 4'h0;
  logic       irq, irq4;
  int         nvec = 0;
  int         nmis = 0;

  irq_ctrl #(.NSRC(8)) u_dut (
    .clk(clk), .rst(rst), .dbr(dbr), .dbw(dbw), .addr(addr),
    .we(we), .src(src), .irq(irq)
  );

  irq_ctrl #(.NSRC(4)) u_dut4 (
    .clk(clk), .rst(rst), .dbr(dbr4), .dbw(dbw), .addr(addr),
    .we(we4), .src(src4), .irq(irq4)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    nvec++;
    if (got !== exp) begin
      nmis++;
      $display("FAIL %s: got %02h expected %02h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [7:0] d, input bit four = 1'b0);
    addr = a;
    dbw  = d;
    we   = !four;
    we4  = four;
    tick(1);
    we   = 1'b0;
    we4  = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a);
    addr = a;
    tick(1);
  endtask

  initial begin
    // Reset with all sources high
    src = 8'hFF;
    tick(3);
    check("rst_irq", {7'b0, irq}, 8'h00);
    check("rst_dbr", dbr, 8'h00);
    rst = 1'b1;
    tick(4);
    rd(2'd0); check("rst_pend", dbr, 8'hFF);
    rd(2'd1); check("rst_mask", dbr, 8'h00);
    rd(2'd2); check("rst_mode", dbr, 8'h00);
    rd(2'd3); check("rst_vec",  dbr, 8'h00);
    check("rst_irq_post", {7'b0, irq}, 8'h00);

    // Level source latency and ignored W1C
    src = 8'h00;
    tick(4);
    wr(2'd1, 8'h01);
    src = 8'h01;
    tick(3);
    check("lvl_e3_irq", {7'b0, irq}, 8'h00);
    tick(1);
    check("lvl_e4_irq", {7'b0, irq}, 8'h01);
    rd(2'd0); check("lvl_pend", dbr, 8'h01);
    src = 8'h00;
    wr(2'd0, 8'h01);
    tick(1); check("lvl_f2_irq", {7'b0, irq}, 8'h01);
    tick(1); check("lvl_f3_irq", {7'b0, irq}, 8'h01);
    tick(1); check("lvl_f4_irq", {7'b0, irq}, 8'h00);

    // Edge capture and W1C
    wr(2'd2, 8'hFF);
    wr(2'd1, 8'hFF);
    src = 8'h20;
    tick(2);
    src = 8'h00;
    tick(4);
    rd(2'd0); check("edge_pend", dbr, 8'h20);
    rd(2'd3); check("edge_vec",  dbr, 8'h85);
    check("edge_irq", {7'b0, irq}, 8'h01);
    wr(2'd0, 8'h20);
    rd(2'd0); check("w1c_pend", dbr, 8'h00);
    check("w1c_irq", {7'b0, irq}, 8'h00);

    // Priority and masking
    src = 8'h44;
    tick(2);
    src = 8'h00;
    tick(4);
    rd(2'd3); check("prio_vec82", dbr, 8'h82);
    wr(2'd0, 8'h04);
    rd(2'd3); check("prio_vec86", dbr, 8'h86);
    wr(2'd1, 8'hBF);
    rd(2'd3); check("prio_vec00", dbr, 8'h00);
    tick(1);
    check("prio_irq", {7'b0, irq}, 8'h00);
    rd(2'd0); check("prio_pend", dbr, 8'h40);

    // Set beats clear on the same edge
    wr(2'd1, 8'hFF);
    wr(2'd3, 8'h03);
    src = 8'h08;
    tick(2);
    wr(2'd0, 8'h08);
    rd(2'd0); check("coll_pend", dbr, 8'h48);
    wr(2'd0, 8'h48);
    rd(2'd0); check("coll_clear", dbr, 8'h00);
    src = 8'h00;

    // Software trigger
    wr(2'd2, 8'h00);
    wr(2'd1, 8'h80);
    tick(3);
    wr(2'd3, 8'h07);
    rd(2'd0); check("swt_lvl_pend", dbr, 8'h00);
    check("swt_lvl_irq", {7'b0, irq}, 8'h00);
    wr(2'd2, 8'h80);
    wr(2'd3, 8'h07);
    check("swt_w_irq", {7'b0, irq}, 8'h00);
    rd(2'd0); check("swt_pend", dbr, 8'h80);
    check("swt_irq", {7'b0, irq}, 8'h01);
    wr(2'd2, 8'h88);
    wr(2'd3, 8'h0B);
    rd(2'd0); check("swt_bit3", dbr, 8'h88);

    // Narrow instance: out-of-range trigger ignored, in-range accepted
    wr(2'd2, 8'hFF, 1'b1);
    rd(2'd2); check("n4_mode", dbr4, 8'h0F);
    wr(2'd3, 8'h06, 1'b1);
    rd(2'd0); check("n4_oor", dbr4, 8'h00);
    wr(2'd3, 8'h0B, 1'b1);
    rd(2'd0); check("n4_bit3", dbr4, 8'h08);
    check("n4_irq", {7'b0, irq4}, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

// File: doc/irq_ctrl.md
# irq_ctrl

Memory-mapped interrupt controller for the 6502 system bus. It collects up to eight peripheral interrupt sources (timer, uart, future blocks) and latches them as pending per source. Each source is masked individually and prioritised by index. The block drives the single CPU `IRQ` line. It attaches to the bus exactly like the other peripherals: registered read data, a write strobe already qualified by the address decode, and a 2-bit register address, planned at $FE40-$FE5F.

## Interface

Parameters:

- NSRC, 8, number of interrupt sources, 1..8; register bits at or above NSRC read 0 and ignore writes

Ports:

- clk  input  1  system clock; all state changes on its rising edge
- rst  input  1  asynchronous, active-low reset; one clock, reset is asynchronous and active-low
- dbr  output  8  read data, registered
- dbw  input  8  write data from CPU
- addr  input  2  register select
- we  input  1  write strobe, pre-qualified by chip select
- src  input  NSRC  raw interrupt requests, asynchronous to clk, active-high
- irq  output  1  interrupt request to CPU, active-high, registered

## Operation

- Input path: each `src` bit passes through a 2-flop synchronizer (`s1`, `s2`) and one history flop `s3` used for edge detection.
- Register map, by `addr`:
  - 0 PEND:
    - Read: pending bits.
    - Write: write-1-to-clear, effective on edge-mode bits only; level-mode bits ignore writes.
  - 1 MASK:
    - Read/write enable per source; 1 = enabled.
  - 2 MODE:
    - Read/write per source; 1 = edge-triggered, 0 = level.
  - 3 VEC:
    - Read: `{any, 4'b0, idx[2:0]}`. `any` = |(PEND & MASK). `idx` = lowest-numbered set bit of PEND & MASK, which is the highest priority. When `any` = 0, `idx` = 0.
    - Write: software trigger. Sets PEND[dbw[2:0]] if that source is edge-mode and dbw[2:0] < NSRC; otherwise no effect.
- Pending update, every cycle, per source i:
  - Level mode: PEND[i] <= s2[i]; it follows the synchronized input.
  - Edge mode: PEND[i] is set on `s2[i] & ~s3[i]` or on a software trigger. It is cleared by a PEND W1C bit. If set and clear happen in the same cycle, set wins.
  - Writing MODE from edge to level: PEND[i] takes s2[i] on the next edge.
  - Writing MODE from level to edge: PEND[i] holds its current value until it is cleared.
- `irq` <= |(PEND & MASK), registered from the current register values.
- Reads have no side effects. CPU dummy reads must not acknowledge anything; acknowledge is only by PEND W1C.
- Masking never clears PEND. A masked pending source asserts `irq` as soon as it is enabled.

## Timing

- Reset (rst=0, asynchronous) clears:
  - `s1`, `s2`, `s3`
  - PEND, MASK, MODE (all level)
  - `dbr` = 8'h00
  - `irq` = 0
- Release of reset is synchronous to the next clk edge.
- Read: at each posedge, `dbr` <= register[addr], using the values before that edge's updates. Data is valid in the cycle after the address, which matches the registered chip select in the bus mux.
- Write: takes effect at the posedge where `we` = 1. A read of the same register on the following posedge returns the new value.
- Source to PEND latency, counted from the first posedge that samples `src` high (edge E1 into `s1`):
  - `s2` at E2
  - PEND at E3
  - `irq` at E4
- PEND W1C or MASK clear at edge W drops `irq` at W+1, provided nothing else is pending and enabled.
- Software trigger at edge W: PEND set at W, `irq` at W+1.
- Edge mode:
  - A `src` high pulse must last at least 2 clk cycles to be captured.
  - Each rising edge of `s2` re-sets PEND, including a re-rise immediately after a clear.
- Level mode: `irq` deasserts 3 edges after `src` falls, if no other source is enabled and pending.
- Reset asserted mid-operation loses all pending state. No partial write is retained.

## Test plan

- Reset:
  - Stimulus: hold rst=0 with src=8'hFF.
  - Required: irq=0, dbr=00; reads after release return PEND=FF (level mode), MASK=00, MODE=00, VEC=00.
- Level source latency:
  - Stimulus: MASK=01, src[0] rises before edge E1.
  - Required: irq=1 at E4.
  - Stimulus: src[0] falls.
  - Required: irq=0 three edges later; a PEND W1C write meanwhile has no effect.
- Edge mode and W1C:
  - Stimulus: MODE=FF, MASK=FF, pulse src[5] for 2 cycles.
  - Required: PEND=20, VEC=85, irq=1.
  - Stimulus: write PEND=20.
  - Required: PEND=00, irq=0 next cycle.
- Priority:
  - Stimulus: edge mode, src[6] and src[2] pulsed together.
  - Required: VEC=82.
  - Stimulus: clear bit 2.
  - Required: VEC=86.
  - Stimulus: MASK=BF.
  - Required: VEC=00, irq=0, PEND still 40.
- Set versus clear collision:
  - Stimulus: write PEND=08 on the same edge a new src[3] rise reaches `s2`.
  - Required: PEND[3]=1 afterward.
- Software trigger:
  - Stimulus: MODE=00, MASK=80, write VEC=07.
  - Required: no effect.
  - Stimulus: MODE=80, write VEC=07.
  - Required: PEND=80, irq=1 one cycle later.
  - Stimulus: write VEC=0B.
  - Required: sets bit 3.
  - Stimulus: with NSRC=4, write VEC=06.
  - Required: ignored.
